// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, FSM state encoding and flag bit positions.
// Also used by the decoder/control unit, so ALU_MUL stays defined even when ALU_MUL_EN is not.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    function automatic logic op_is_mul(input logic [3:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
// prod is combinational so the owner can capture the final product on the same edge as done.
import alu_pkg::*;

module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;

    // Partial sum including the bit being processed this cycle.
    assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done = busy_q && (count_q == CW'(WIDTH - 1));
    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= prod;
            mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            count_q  <= count_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and NZCV flags.
// Define ALU_MUL_EN to enable the iterative multiplier on opcode 1010.
import alu_pkg::*;

module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Aout,
    output logic             zeroFlag,
    output logic             negFlag,
    output logic             carryFlag,
    output logic             ovfFlag
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e        state_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  aout_q;
    logic [FLAG_W-1:0] flags_q;

    logic [WIDTH-1:0]  res_d;
    logic [FLAG_W-1:0] flags_d;
    logic              carry_d;
    logic              ovf_d;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [SHW-1:0]    shamt;
    logic              accept;

    // Held low during the reset cycle itself so upstream never hands over a dropped operand.
    assign in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    assign shamt    = a2[SHW-1:0];
    assign sum_ext  = {1'b0, a1} + {1'b0, a2};
    // a1 + ~a2 + 1: the carry out is 1 exactly when no borrow occurs.
    assign diff_ext = {1'b0, a1} + {1'b0, ~a2} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (ALU_control)
            ALU_AND:  res_d = a1 & a2;
            ALU_OR:   res_d = a1 | a2;
            ALU_XOR:  res_d = a1 ^ a2;
            ALU_ADD: begin
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
                ovf_d   = (a1[WIDTH-1] == a2[WIDTH-1]) && (sum_ext[WIDTH-1] != a1[WIDTH-1]);
            end
            ALU_SUB: begin
                res_d   = diff_ext[WIDTH-1:0];
                carry_d = diff_ext[WIDTH];
                ovf_d   = (a1[WIDTH-1] != a2[WIDTH-1]) && (diff_ext[WIDTH-1] != a1[WIDTH-1]);
            end
            ALU_SLL:  res_d = a1 << shamt;
            ALU_SRL:  res_d = a1 >> shamt;
            ALU_SRA:  res_d = $signed(a1) >>> shamt;
            ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a1) < $signed(a2))};
            ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a1 < a2)};
            default:  res_d = '0;
        endcase
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_Z] = (res_d == '0);
        flags_d[FLAG_N] = res_d[WIDTH-1];
        flags_d[FLAG_C] = carry_d;
        flags_d[FLAG_V] = ovf_d;
    end

`ifdef ALU_MUL_EN
    logic              is_mul;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [WIDTH-1:0]  mul_prod;
    logic [FLAG_W-1:0] mul_flags;

    assign is_mul    = op_is_mul(ALU_control);
    assign mul_start = accept && is_mul;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a1),
        .b     (a2),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod == '0);
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            aout_q      <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
`ifdef ALU_MUL_EN
                    if (mul_start) begin
                        // Previous result is considered consumed; Aout keeps its old value.
                        state_q     <= ST_MUL;
                        out_valid_q <= 1'b0;
                    end else
`endif
                    if (accept) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        aout_q      <= res_d;
                        flags_q     <= flags_d;
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        aout_q      <= mul_prod;
                        flags_q     <= mul_flags;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign Aout      = aout_q;
    assign zeroFlag  = flags_q[FLAG_Z];
    assign negFlag   = flags_q[FLAG_N];
    assign carryFlag = flags_q[FLAG_C];
    assign ovfFlag   = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner sequences then random traffic against a transaction model.
// Honors ALU_MUL_EN the same way the design does.
module tb_alu_pipe;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] a2 = '0;
    logic [3:0]       ALU_control = 4'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] Aout;
    logic             zeroFlag;
    logic             negFlag;
    logic             carryFlag;
    logic             ovfFlag;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a1          (a1),
        .a2          (a2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Aout        (Aout),
        .zeroFlag    (zeroFlag),
        .negFlag     (negFlag),
        .carryFlag   (carryFlag),
        .ovfFlag     (ovfFlag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    // Transaction model: what the consumer should currently see.
    logic        m_have  = 1'b0;
    int          m_busy  = 0;
    logic [31:0] m_aout  = '0;
    logic [3:0]  m_flags = '0;   // {V,C,N,Z}
    logic [35:0] m_mulres = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'b1010;
`else
        return 1'b0;
`endif
    endfunction

    // Returns {V,C,N,Z,result} from plain integer arithmetic.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic [31:0] r;
        logic c, v;
        logic [4:0] sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = b[4:0];
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0010: begin
                r  = 32'(ua + ub);
                c  = ((ua + ub) >= 64'h1_0000_0000);
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                r  = 32'(sa - sb);
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0100: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1101: r = 32'(sa >>> sh);
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'b1010: r = 32'(ua * ub);
`endif
            default: r = '0;
        endcase
        return {v, c, r[31], (r == 32'd0), r};
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic ordy, input logic r);
        logic m_rdy, acc, drain;
        rst = r; in_valid = v; ALU_control = op; a1 = x; a2 = y; out_ready = ordy;
        #1;
        m_rdy = !r && ((!m_have && m_busy == 0) || (m_have && ordy));
        check_val("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
        @(posedge clk);
        if (r) begin
            m_have = 1'b0; m_busy = 0; m_aout = '0; m_flags = '0;
        end else begin
            acc   = v && m_rdy;
            drain = m_have && ordy;
            if (drain) begin
                n_xfer++;
                $display("xfer %0d: Aout=0x%08h flags(VCNZ)=%b", n_xfer, m_aout, m_flags);
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_have = 1'b1;
                    {m_flags, m_aout} = m_mulres;
                end
            end else if (drain) begin
                m_have = 1'b0;
            end
            if (acc) begin
                if (is_mul_op(op)) begin
                    m_busy = WIDTH; m_have = 1'b0; m_mulres = ref_alu(op, x, y);
                end else begin
                    m_have = 1'b1; {m_flags, m_aout} = ref_alu(op, x, y);
                end
            end
        end
        @(negedge clk);
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_have});
        check_val("Aout", {32'd0, Aout}, {32'd0, m_aout});
        check_val("flags", {60'd0, ovfFlag, carryFlag, negFlag, zeroFlag}, {60'd0, m_flags});
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        @(negedge clk);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Signed overflow on ADD.
        step(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Back-to-back SUBs, equal then borrowing.
        step(1'b1, 4'b0110, 32'd5, 32'd5, 1'b1, 1'b0);
        step(1'b1, 4'b0110, 32'd3, 32'd5, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Shifts use only the low shamt bits; SLT is signed.
        step(1'b1, 4'b1101, 32'h8000_0000, 32'h24, 1'b1, 1'b0);
        step(1'b1, 4'b0101, 32'h8000_0000, 32'h24, 1'b1, 1'b0);
        step(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        step(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Backpressure: AND result held for three cycles while upstream keeps offering.
        step(1'b1, 4'b0000, 32'hF0F0_1234, 32'hFF00_FF0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 32'h1, 32'h2, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Opcode 1010: multiply when enabled, otherwise undefined.
        step(1'b1, 4'b1010, 32'd12, 32'd13, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH + 2; i++) step(1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Reset part way through a multiply (or a held result) drops it.
        step(1'b1, 4'b1010, 32'd7, 32'd9, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < WIDTH + 2; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
